// File: rtl/multiport_register_file.sv
// Multi-read-port register file: one write port, READ_PORTS registered read ports with 1-cycle latency.
// Define WRITE_BYPASS_EN for write-first forwarding on same-cycle read/write collisions (read-first otherwise).
module multiport_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned READ_PORTS = 2,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [READ_PORTS-1:0]            read_enable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_register,
  input  logic [ADDR_WIDTH-1:0]            write_register,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             RegWrite,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            read_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]            regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]            regs_d [DEPTH];
  logic [READ_PORTS*DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [READ_PORTS-1:0]            read_valid_q, read_valid_d;

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (RegWrite && (write_register == ADDR_WIDTH'(i))) begin
        regs_d[i] = write_data;
      end
    end
    if (ZERO_REG) begin
      regs_d[0] = '0;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    raddr        = '0;
    rdata        = '0;
    read_data_d  = read_data_q;
    read_valid_d = read_enable;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      raddr = read_register[p*ADDR_WIDTH +: ADDR_WIDTH];
      rdata = regs_q[raddr];
`ifdef WRITE_BYPASS_EN
      if (RegWrite && (write_register == raddr)) begin
        rdata = write_data;
      end
`endif
      // Zero-register override comes last so forwarding can never leak a write to r0.
      if (ZERO_REG && (raddr == '0)) begin
        rdata = '0;
      end
      if (read_enable[p]) begin
        read_data_d[p*DATA_WIDTH +: DATA_WIDTH] = rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      read_data_q  <= '0;
      read_valid_q <= '0;
    end else begin
      regs_q       <= regs_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule
